// File: rtl/fp_add_sequencer_if.sv
// fp_add_sequencer_if: issuer/datapath-facing signal bundle for fp_add_sequencer
interface fp_add_if;
    logic        start;
    logic        sub;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [2:0]  flags;
    logic [31:0] dp_a;
    logic [31:0] dp_b;
    logic [3:0]  dp_en;
    logic [31:0] dp_num;
    modport master (output start, sub, a_in, b_in, dp_num,
                    input busy, done, result, flags, dp_a, dp_b, dp_en);
    modport slave  (input start, sub, a_in, b_in, dp_num,
                    output busy, done, result, flags, dp_a, dp_b, dp_en);
endinterface

// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: sequences a 4-stage FP adder datapath with IEEE special-operand bypass; FP_SEQ_FLAGS_EN enables flags
module fp_add_sequencer #(
    parameter int STAGE_CYCLES = 1
) (
    input logic     clk,
    input logic     rst,
    fp_add_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CMP, SHIFT, ADD, NORM, CAPT, DONE} state_t;
    state_t      state;
    logic [3:0]  cnt;
    logic        last;
    logic        nan, inf_opp, inf_a, inf_b, za, zb, special;
    logic [31:0] byp_res;
    logic [2:0]  byp_fl, cap_fl;
    assign last = cnt == 4'(STAGE_CYCLES - 1);
    // Classify the latched operands and form the bypass result, first match wins
    always_comb begin
        inf_a   = bus.dp_a[30:23] == 8'hFF && bus.dp_a[22:0] == '0;
        inf_b   = bus.dp_b[30:23] == 8'hFF && bus.dp_b[22:0] == '0;
        nan     = (bus.dp_a[30:23] == 8'hFF && !inf_a) || (bus.dp_b[30:23] == 8'hFF && !inf_b);
        inf_opp = inf_a && inf_b && (bus.dp_a[31] ^ bus.dp_b[31]);
        za      = bus.dp_a[30:23] == 8'h00;
        zb      = bus.dp_b[30:23] == 8'h00;
        special = nan || inf_a || inf_b || za || zb;
        byp_res = (nan || inf_opp) ? 32'h7FC00000 :
                  inf_a ? bus.dp_a :
                  inf_b ? bus.dp_b :
                  (za && zb) ? {bus.dp_a[31] & bus.dp_b[31], 31'b0} :
                  za ? bus.dp_b : bus.dp_a;
    end
`ifdef FP_SEQ_FLAGS_EN
    assign byp_fl = {nan || inf_opp, 1'b0, !(nan || inf_a || inf_b) && za && zb};
    assign cap_fl = {1'b0, bus.dp_num[30:23] == 8'hFF, bus.dp_num[30:0] == '0};
`else
    assign byp_fl = 3'b000;
    assign cap_fl = 3'b000;
`endif
    // Control FSM: stage enables lag the state by one cycle so the bypass decision precedes any enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.dp_en  <= '0;
            bus.result <= '0;
            bus.flags  <= '0;
            bus.dp_a   <= '0;
            bus.dp_b   <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    bus.dp_a <= bus.a_in;
                    bus.dp_b <= {bus.b_in[31] ^ bus.sub, bus.b_in[30:0]};
                    bus.busy <= 1'b1;
                    cnt      <= '0;
                    state    <= CMP;
                end
                CMP: if (special) begin
                    bus.result <= byp_res;
                    bus.flags  <= byp_fl;
                    state      <= DONE;
                end else begin
                    bus.dp_en <= 4'b1000;
                    cnt       <= last ? '0 : cnt + 4'd1;
                    state     <= last ? SHIFT : CMP;
                end
                SHIFT: begin
                    bus.dp_en <= 4'b0100;
                    cnt       <= last ? '0 : cnt + 4'd1;
                    state     <= last ? ADD : SHIFT;
                end
                ADD: begin
                    bus.dp_en <= 4'b0010;
                    cnt       <= last ? '0 : cnt + 4'd1;
                    state     <= last ? NORM : ADD;
                end
                NORM: begin
                    bus.dp_en <= 4'b0001;
                    cnt       <= last ? '0 : cnt + 4'd1;
                    state     <= last ? CAPT : NORM;
                end
                CAPT: begin
                    bus.dp_en  <= '0;
                    bus.result <= bus.dp_num;
                    bus.flags  <= cap_fl;
                    state      <= DONE;
                end
                DONE: begin
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/fp_add_sequencer.md
Name: fp_add_sequencer

Overview:
- Control-side initiator for the staged floating-point adder datapath. That datapath is a four-stage unit with one enable per stage: compare, align shift, add, normalize. It has no control of its own.
- This block latches operands and issues the one-hot stage enables in order. It captures the normalized result and returns it over a start/done handshake.
- It bypasses the datapath for IEEE-754 special operands (NaN, infinity, zero/denormal).
- Sits between the operation issuer (top-level FSM / UI logic) and the adder datapath. Also provides subtraction by sign-flipping operand B.

Parameters:
- STAGE_CYCLES, 1, cycles each datapath enable is held asserted (1..15); allows slow combinational stages.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  1 = A-B, 0 = A+B; latched with start.
- a_in  input  32  operand A, IEEE-754 single; latched with start.
- b_in  input  32  operand B, IEEE-754 single; latched with start.
- busy  output  1  high from the edge after start is accepted until the edge done asserts.
- done  output  1  one-cycle pulse; result valid from this cycle until the next accepted start.
- result  output  32  registered sum/difference.
- flags  output  3  {invalid, overflow, zero}; registered with result.
- dp_a  output  32  operand A to datapath (latched copy).
- dp_b  output  32  operand B to datapath (latched; sign inverted when sub=1).
- dp_en  output  4  stage enables to datapath: [3]=compare, [2]=shift, [1]=add, [0]=normalize.
- dp_num  input  32  normalized result from datapath.

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - busy, done, dp_en, result, flags, dp_a, dp_b all 0.
  - Stage counter 0.
- States: IDLE, CMP, SHIFT, ADD, NORM, CAPT, DONE.
- IDLE, start=1 at edge 0:
  - Latch dp_a=a_in, dp_b={b_in[31]^sub, b_in[30:0]}.
  - Classify the latched pair. If special, go to DONE with the bypass result; otherwise go to CMP.
- Enables per state (one-hot, exactly one bit high, zero elsewhere):
  - CMP: dp_en=4'b1000.
  - SHIFT: dp_en=4'b0100.
  - ADD: dp_en=4'b0010.
  - NORM: dp_en=4'b0001.
- Each of CMP/SHIFT/ADD/NORM lasts exactly STAGE_CYCLES cycles. Stage counter resets on each state entry.
- CAPT: dp_en=0; result<=dp_num; flags computed from dp_num; go to DONE.
- DONE: done=1 for one cycle, busy=0; next state IDLE.
- Latency:
  - Normal path: done high in the cycle after edge 4*STAGE_CYCLES+2 (6 for default).
  - Bypass: done high after edge 2.
- start while busy: ignored, no queuing.
- start held high continuously: a new operation is accepted in every IDLE cycle, i.e. back-to-back with one IDLE cycle between done and the next acceptance.
- Operands a_in/b_in/sub are don't-care after acceptance.
- Special-case bypass (E = exponent field, M = mantissa), evaluated on latched dp_a/dp_b, first match wins:
  - Either NaN (E=FF, M≠0): result=32'h7FC00000, invalid.
  - +inf and -inf: result=32'h7FC00000, invalid.
  - One or both inf: result = that inf.
  - E=0 on both: result = +0, except (-0)+(-0) = 32'h80000000; zero flag.
  - E=0 on one: result = the other operand unchanged (denormals flushed to zero).
- Flags on the normal path:
  - overflow = dp_num[30:23]==8'hFF.
  - zero = dp_num[30:0]==0.
  - invalid = 0.
- Reset mid-operation: abort immediately to reset values; dp_en drops in the same cycle; no done pulse.

Optional Feature:
- Macro: FP_SEQ_FLAGS_EN.
- Defined: flags computed and registered as described.
- Undefined: flags tied to 3'b000 and no flag logic synthesized. Bypass results are unchanged.

Test Plan:
- Add 1.5+2.25: a_in=3FC00000, b_in=40100000, sub=0, start at edge 0, model returns correct sum.
  - dp_en sequence 8,4,2,1 on edges 1-4.
  - done after edge 6; result=40700000; flags=000.
- Subtract 5.0-5.0: a_in=b_in=40A00000, sub=1.
  - dp_b=C0A00000.
  - Model returns 00000000 -> result=00000000, flags=001.
- Bypass: a_in=7F800000, b_in=FF800000.
  - dp_en stays 0; done after edge 2; result=7FC00000, flags=100.
  - Repeat with a_in=00000000, b_in=C1200000 -> result=C1200000 after edge 2.
- STAGE_CYCLES=3: each dp_en value held exactly 3 cycles; done after edge 14.
  - start pulsed during busy at edge 5 is ignored: exactly one done.
- Reset mid-op: assert rst while dp_en=4'b0010.
  - All outputs 0 immediately; no done.
  - After release, a new start completes normally.
